data_crc_status_tx: RTL and testbench
=====================================

DATA_CRC_STATUS_TX -- requirements
Module: data_crc_status_tx

Interface
REQ-001 Parameter NCRC_DELAY, default 2, SHALL set the number of released-line clock periods between start acceptance and the start bit; legal range 0..15.
REQ-002 Parameter BUSY_CYCLES, default 8, SHALL set the number of DAT0-low busy periods after an accepted token; legal range 1..255.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 ENA  in  1  level enable; a rising level in IDLE starts one token, deassertion aborts.
REQ-006 CRC_OK  in  1  1 = received write block CRC16 matched; sampled at start acceptance only.
REQ-007 WR_ERR  in  1  1 = card write error; sampled at start acceptance only.
REQ-008 DAT0_OUT  out  1  serial value driven onto DAT0.
REQ-009 DAT0_OE  out  1  1 = DAT0_OUT drives the line; 0 = line released.
REQ-010 BUSY  out  1  1 while busy phase is driven.
REQ-011 COMPLT  out  1  1 = token (and busy, if any) finished; held until ENA low.
REQ-012 ERROR  out  1  1 = token sent was not "accepted"; valid while COMPLT=1.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, START, STATUS, END, BUSY, DONE; all outputs registered.
REQ-014 Start acceptance: edge where state=IDLE and ENA=1; status latched, state -> WAIT (or START if NCRC_DELAY=0).
REQ-015 Status code latched SHALL be: WR_ERR=1 -> 110; else CRC_OK=0 -> 101; else 010 (WR_ERR has priority).
REQ-016 WAIT: DAT0_OE=0, DAT0_OUT=1 for exactly NCRC_DELAY periods.
REQ-017 START: one period, DAT0_OE=1, DAT0_OUT=0.
REQ-018 STATUS: three periods, DAT0_OE=1, status bits MSB first.
REQ-019 END: one period, DAT0_OE=1, DAT0_OUT=1.
REQ-020 After END with status 010: BUSY for exactly BUSY_CYCLES periods, DAT0_OE=1, DAT0_OUT=0, BUSY=1; then DONE.
REQ-021 After END with status 101 or 110: no busy phase; go directly to DONE.
REQ-022 DONE: DAT0_OE=0, COMPLT=1, ERROR=(status!=010); held while ENA=1.
REQ-023 ENA=0 in any state SHALL return to IDLE on that edge with DAT0_OE=0, BUSY=0, COMPLT=0, ERROR=0 (abort, no partial token continues).
REQ-024 CRC_OK/WR_ERR changes after acceptance SHALL NOT affect the token in flight.
REQ-025 A new token requires ENA low for at least one edge then high again; ENA held high after DONE SHALL NOT restart.
REQ-026 Phase counter SHALL be 8 bits, down-counting, no wrap: reaching 0 ends the phase.

Reset
REQ-027 RST=1 at an edge SHALL force IDLE, DAT0_OUT=1, DAT0_OE=0, BUSY=0, COMPLT=0, ERROR=0, counter=0, status=010, regardless of ENA or state; RST dominates ENA.
REQ-028 RST mid-token SHALL release the line on the same edge; after RST falls, ENA already high counts as a new start.

Structure
REQ-029 Shared package SHALL hold: status codes (010 ACCEPTED, 101 CRC_ERR, 110 WR_ERR), token width 5, state encoding.
REQ-030 One sub-module, sd_phase_counter (loadable 8-bit down counter with zero flag), SHALL time WAIT, STATUS and BUSY.

Verification
REQ-031 NCRC_DELAY=2, BUSY_CYCLES=4, CRC_OK=1, WR_ERR=0, ENA rises before edge 0 -> released edges 0-1; DAT0 sequence after edges 2..6 = 0,0,1,0,1; low after edges 7-10 with BUSY=1; COMPLT=1, ERROR=0, DAT0_OE=0 after edge 11.
REQ-032 Same params, CRC_OK=0 -> sequence 0,1,0,1,1; no busy; COMPLT=1, ERROR=1 after edge 7.
REQ-033 CRC_OK=0 and WR_ERR=1 -> status bits 110, ERROR=1; CRC_OK toggled after edge 0 -> token unchanged.
REQ-034 NCRC_DELAY=0 -> start bit driven after edge 0; token and busy shift 2 edges earlier than REQ-031.
REQ-035 ENA dropped during STATUS, and separately RST asserted during BUSY -> DAT0_OE=0, COMPLT=0 on that edge; next ENA rise produces a full correct token.
REQ-036 Loopback: this block's DAT0 into the host-side CRC status receiver -> receiver reports complete without error for 010, complete with error for 101/110.

Source files
------------

// File: rtl/data_crc_status_tx_pkg.sv
// data_crc_status_tx_pkg: shared status codes, token width and state encoding
package data_crc_status_tx_pkg;
  localparam int TOKEN_W = 5;
  localparam logic [2:0] ST_ACCEPTED = 3'b010;
  localparam logic [2:0] ST_CRC_ERR = 3'b101;
  localparam logic [2:0] ST_WR_ERR = 3'b110;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_STATUS, S_END, S_BUSY, S_DONE} state_e;
  function automatic logic [2:0] status_code(input logic crc_ok, input logic wr_err);
    return wr_err ? ST_WR_ERR : (!crc_ok ? ST_CRC_ERR : ST_ACCEPTED);
  endfunction
endpackage

// File: rtl/data_crc_status_tx_if.sv
// data_crc_status_tx_if: host-side control and DAT0 line signals of the status token sender
interface data_crc_status_tx_if;
  logic ena;
  logic crc_ok;
  logic wr_err;
  logic dat0_out;
  logic dat0_oe;
  logic busy;
  logic complt;
  logic error;
  modport master (output ena, crc_ok, wr_err, input dat0_out, dat0_oe, busy, complt, error);
  modport slave (input ena, crc_ok, wr_err, output dat0_out, dat0_oe, busy, complt, error);
endinterface

// File: rtl/data_crc_status_tx_counter.sv
// sd_phase_counter: loadable 8-bit down counter that holds at zero
module sd_phase_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic [7:0] cnt_o,
  output logic       zero_o
);
  logic [7:0] cnt_q, cnt_d;
  // next count: load wins, decrement stops at zero
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
  // count register
  always_ff @(posedge clk_i)
    if (rst_i) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign zero_o = cnt_q == 8'd0;
endmodule

// File: rtl/data_crc_status_tx.sv
// data_crc_status_tx: drives the SD write CRC status token and busy phase on DAT0
module data_crc_status_tx
  import data_crc_status_tx_pkg::*;
#(
  parameter int NCRC_DELAY  = 2,
  parameter int BUSY_CYCLES = 8
) (
  input logic clk_i,
  input logic rst_i,
  data_crc_status_tx_if.slave bus
);
  state_e state_q, state_d;
  logic [2:0] status_q, status_d;
  logic dat0_q, dat0_d, oe_q, oe_d, busy_q, busy_d, complt_q, complt_d, error_q, error_d;
  logic load, dec, zero;
  logic [7:0] load_val, cnt;
  logic [1:0] idx;
  sd_phase_counter u_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load), .load_val_i(load_val),
    .dec_i(dec), .cnt_o(cnt), .zero_o(zero)
  );
  // state, latched status and registered outputs
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      status_q <= ST_ACCEPTED;
      dat0_q <= 1'b1;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      complt_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      dat0_q <= dat0_d;
      oe_q <= oe_d;
      busy_q <= busy_d;
      complt_q <= complt_d;
      error_q <= error_d;
    end
  // next state; phase lengths are loaded as length-1 and end when the counter reads zero
  always_comb begin
    state_d = state_q;
    status_d = status_q;
    load = 1'b0;
    load_val = 8'd0;
    dec = 1'b0;
    if (!bus.ena) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE: begin
          status_d = status_code(bus.crc_ok, bus.wr_err);
          state_d = (NCRC_DELAY == 0) ? S_START : S_WAIT;
          load = NCRC_DELAY != 0;
          load_val = 8'(NCRC_DELAY - 1);
        end
        S_WAIT: begin
          state_d = zero ? S_START : S_WAIT;
          dec = 1'b1;
        end
        S_START: begin
          state_d = S_STATUS;
          load = 1'b1;
          load_val = 8'd2;
        end
        S_STATUS: begin
          state_d = zero ? S_END : S_STATUS;
          dec = 1'b1;
        end
        S_END: begin
          state_d = (status_q == ST_ACCEPTED) ? S_BUSY : S_DONE;
          load = status_q == ST_ACCEPTED;
          load_val = 8'(BUSY_CYCLES - 1);
        end
        S_BUSY: begin
          state_d = zero ? S_DONE : S_BUSY;
          dec = 1'b1;
        end
        default: state_d = S_DONE;
      endcase
  end
  // outputs follow the state being entered so they line up with it after the edge
  always_comb begin
    idx = (state_q == S_STATUS) ? 2'(cnt - 8'd1) : 2'd2;
    oe_d = state_d inside {S_START, S_STATUS, S_END, S_BUSY};
    dat0_d = (state_d == S_START || state_d == S_BUSY) ? 1'b0 : (state_d == S_STATUS) ? status_q[idx] : 1'b1;
    busy_d = state_d == S_BUSY;
    complt_d = state_d == S_DONE;
    error_d = complt_d && status_d != ST_ACCEPTED;
  end
  assign bus.dat0_out = dat0_q;
  assign bus.dat0_oe = oe_q;
  assign bus.busy = busy_q;
  assign bus.complt = complt_q;
  assign bus.error = error_q;
endmodule

// File: tb/tb_data_crc_status_tx.sv
// tb_data_crc_status_tx: directed checks of token timing, status codes, abort and reset
module tb_data_crc_status_tx;
  import data_crc_status_tx_pkg::*;
  logic clk = 1'b0, rst = 1'b1, crc_ok = 1'b1, wr_err = 1'b0, ena_a = 1'b0, ena_b = 1'b0, sel = 1'b0;
  logic o_dat, o_oe, o_busy, o_cpl, o_err;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  data_crc_status_tx_if ia ();
  data_crc_status_tx_if ib ();
  assign ia.ena = ena_a;
  assign ia.crc_ok = crc_ok;
  assign ia.wr_err = wr_err;
  assign ib.ena = ena_b;
  assign ib.crc_ok = crc_ok;
  assign ib.wr_err = wr_err;
  data_crc_status_tx #(.NCRC_DELAY(2), .BUSY_CYCLES(4)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia.slave));
  data_crc_status_tx #(.NCRC_DELAY(0), .BUSY_CYCLES(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib.slave));
  always_comb begin
    o_dat = sel ? ib.dat0_out : ia.dat0_out;
    o_oe = sel ? ib.dat0_oe : ia.dat0_oe;
    o_busy = sel ? ib.busy : ia.busy;
    o_cpl = sel ? ib.complt : ia.complt;
    o_err = sel ? ib.error : ia.error;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // ena must already be high; steps from the acceptance edge through DONE and the ENA-low return
  task automatic token(input int ncrc, input logic [4:0] seq, input logic flip);
    logic acc;
    logic [4:0] rx;
    acc = seq[3:1] == ST_ACCEPTED;
    rx = '0;
    for (int i = 0; i < ncrc; i++) begin
      step();
      if (flip && i == 0) begin
        crc_ok = ~crc_ok;
        wr_err = ~wr_err;
      end
      chk("wait_oe", o_oe, 1'b0);
      chk("wait_dat", o_dat, 1'b1);
    end
    for (int i = 0; i < TOKEN_W; i++) begin
      step();
      chk("tok_oe", o_oe, 1'b1);
      chk("tok_dat", o_dat, seq[TOKEN_W-1-i]);
      rx = {rx[3:0], o_dat};
    end
    if (acc)
      for (int i = 0; i < 4; i++) begin
        step();
        chk("busy_flag", o_busy, 1'b1);
        chk("busy_oe", o_oe, 1'b1);
        chk("busy_dat", o_dat, 1'b0);
      end
    step();
    chk("done_cpl", o_cpl, 1'b1);
    chk("done_err", o_err, !acc);
    chk("done_oe", o_oe, 1'b0);
    chk("done_busy", o_busy, 1'b0);
    chk("rx_err", rx[4] != 1'b0 || rx[0] != 1'b1 || rx[3:1] != ST_ACCEPTED, !acc);
    step();
    chk("hold_cpl", o_cpl, 1'b1);
    chk("hold_oe", o_oe, 1'b0);
    if (sel) ena_b = 1'b0;
    else ena_a = 1'b0;
    step();
    chk("idle_cpl", o_cpl, 1'b0);
    chk("idle_err", o_err, 1'b0);
  endtask
  initial begin
    step();
    step();
    chk("rst_oe", o_oe, 1'b0);
    chk("rst_dat", o_dat, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cpl", o_cpl, 1'b0);
    chk("rst_err", o_err, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_oe", o_oe, 1'b0);
    crc_ok = 1'b1; wr_err = 1'b0; ena_a = 1'b1;
    token(2, 5'b00101, 1'b0);
    crc_ok = 1'b0; wr_err = 1'b0; ena_a = 1'b1;
    token(2, 5'b01011, 1'b0);
    crc_ok = 1'b0; wr_err = 1'b1; ena_a = 1'b1;
    token(2, 5'b01101, 1'b1);
    sel = 1'b1; crc_ok = 1'b1; wr_err = 1'b0; ena_b = 1'b1;
    token(0, 5'b00101, 1'b0);
    sel = 1'b0;
    ena_a = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("abort_pre_oe", o_oe, 1'b1);
    ena_a = 1'b0;
    step();
    chk("abort_oe", o_oe, 1'b0);
    chk("abort_cpl", o_cpl, 1'b0);
    step();
    chk("abort_idle_oe", o_oe, 1'b0);
    ena_a = 1'b1;
    token(2, 5'b00101, 1'b0);
    ena_a = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_busy", o_busy, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid_oe", o_oe, 1'b0);
    chk("rst_mid_busy", o_busy, 1'b0);
    chk("rst_mid_cpl", o_cpl, 1'b0);
    rst = 1'b0;
    token(2, 5'b00101, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
